mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 512x32 main memory.
- Shares the single memory port between port 0 (CPU MAR/MDR datapath) and port 1 (loader/I/O requester).
- Round-robin grant; drives exactly one memory strobe per transaction for a fixed WAIT_CYCLES window, then captures read data and returns a one-cycle done pulse to the winner.

Parameters:
- WAIT_CYCLES, 2, cycles the Read/Write strobe and address are held per access; legal range 2..15.
- AW, 9, address width.
- DW, 32, data width.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  synchronous active-high reset.
- req0  in  1  port 0 request (level).
- we0  in  1  port 0 write-enable (1 = write, 0 = read).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- done0  out  1  port 0 completion pulse.
- req1, we1, addr1, wdata1, done1  as port 0, for port 1.
- rdata  out  DW  read data of the most recent completed read (either port).
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the port currently or last served.
- mem_Read  out  1  memory read strobe.
- mem_Write  out  1  memory write strobe.
- mem_Address  out  AW  memory address.
- mem_Wdata  out  DW  memory write data.
- mem_Rdata  in  DW  memory read data (registered inside the memory).

Behaviour:
- All outputs are registered.
- Clear reset values:
  - state = IDLE.
  - done0 = done1 = 0; mem_Read = mem_Write = 0.
  - mem_Address = 0, mem_Wdata = 0, rdata = 0.
  - busy = 0; grant = 1, so port 0 wins the first tie.
- Clear asserted mid-transaction aborts it:
  - No done is issued.
  - Strobes drop on the same edge.
  - A write already strobed may have landed in memory.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != grant (round-robin).
  - On grant: latch we, addr and wdata of the winner into mem_* and an internal we register; set grant = winner; load the counter with WAIT_CYCLES-1; assert mem_Read (we = 0) or mem_Write (we = 1); go to ACCESS.
- ACCESS:
  - Hold the strobe, mem_Address and mem_Wdata constant.
  - Changes on the req/we/addr/wdata inputs are ignored.
  - Decrement the counter. At counter = 0: deassert both strobes; if the transaction is a read, load rdata <= mem_Rdata; assert done[grant] = 1; go to RESP.
- RESP:
  - done[grant] is high for exactly this one cycle; then done is cleared and the FSM returns to IDLE.
  - rdata holds its value until the next read completes; writes never alter rdata.
- Access latency: req sampled in IDLE at edge N; done is high from edge N+WAIT_CYCLES to N+WAIT_CYCLES+1.
- Occupancy: a transaction occupies WAIT_CYCLES+2 cycles including IDLE, so back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable until done.
  - Drop req in the done cycle.
  - req still high when IDLE samples it is a new request.
  - req dropped before grant withdraws the request with no side effect.
  - req dropped after grant does not cancel; done is still issued.
- Invariants:
  - mem_Read and mem_Write are never high together.
  - done0 and done1 are never high together.
  - Strobes are only high in ACCESS.
- Fairness: with both ports continuously requesting, grants strictly alternate and neither port waits more than one transaction.
- Address wrap: addr is used as-is, modulo 2^AW; there is no out-of-range condition.

Test Plan:
- Clear for 2 cycles -> all outputs at reset values, busy = 0, grant = 1; with no requests, nothing changes for 10 cycles.
- Port 0 write addr0 = 9'h054, wdata0 = 32'h00000097, WAIT_CYCLES = 2:
  - mem_Write is high for exactly 2 cycles with mem_Address = 9'h054.
  - done0 pulses 1 cycle; rdata is unchanged.
  - A port 1 read of 9'h054 then returns rdata = 32'h00000097 with done1.
- req0 and req1 asserted on the same cycle from reset:
  - Port 0 is served first, then port 1.
  - With both held high for 6 transactions, the grant sequence is 0,1,0,1,0,1.
- Port 1 changes addr1 from 9'h092 to 9'h0B9 during ACCESS -> mem_Address stays 9'h092; rdata = the memory contents at 9'h092.
- Clear asserted during ACCESS of a port 0 read -> next cycle: state IDLE, strobes 0, done0 never pulses, rdata keeps its prior value.
- WAIT_CYCLES = 4, single read -> strobe high for 4 cycles; done at edge N+4; back-to-back reads from one port are spaced 6 cycles apart.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, status and memory-port signals of the two-port memory arbiter
interface mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          done0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          grant;
    logic          mem_Read;
    logic          mem_Write;
    logic [AW-1:0] mem_Address;
    logic [DW-1:0] mem_Wdata;
    logic [DW-1:0] mem_Rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_Rdata,
        output done0, done1, rdata, busy, grant,
               mem_Read, mem_Write, mem_Address, mem_Wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_Rdata,
        input  done0, done1, rdata, busy, grant,
               mem_Read, mem_Write, mem_Address, mem_Wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter sequencing fixed-length accesses to main memory
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 9,
    parameter int DW          = 32
) (
    input  logic          Clock,
    input  logic          Clear,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          grant_q, grant_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          win;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            grant_q <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            grant_q <= grant_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // On a tie the port not served last wins; grant resets to 1 so port 0 takes the first tie.
    always_comb begin
        win = 1'b0;
        if (bus.req0 && bus.req1) begin
            win = ~grant_q;
        end else if (bus.req1) begin
            win = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        grant_d = grant_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d = win;
                    we_d    = win ? bus.we1 : bus.we0;
                    addr_d  = win ? bus.addr1 : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                    rd_d    = ~(win ? bus.we1 : bus.we0);
                    wr_d    = win ? bus.we1 : bus.we0;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.mem_Rdata;
                    end
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.grant       = grant_q;
    assign bus.mem_Read    = rd_q;
    assign bus.mem_Write   = wr_q;
    assign bus.mem_Address = addr_q;
    assign bus.mem_Wdata   = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with WAIT_CYCLES of 2 and 4
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(9), .DW(32)) b ();
    mem_arbiter_if #(.AW(9), .DW(32)) b4 ();

    mem_arbiter #(.WAIT_CYCLES(2), .AW(9), .DW(32)) u_dut (
        .Clock (clk),
        .Clear (rst),
        .bus   (b.slave)
    );
    mem_arbiter #(.WAIT_CYCLES(4), .AW(9), .DW(32)) u_dut4 (
        .Clock (clk),
        .Clear (rst),
        .bus   (b4.slave)
    );

    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem     [512];
    logic [31:0] mem4    [512];
    logic [31:0] exp_mem [512];
    logic [31:0] exp_rdata;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 + 32'(i * 7);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memories with a registered read port
    always @(posedge clk) begin
        if (b.mem_Write) mem[b.mem_Address] <= b.mem_Wdata;
        if (b.mem_Read)  b.mem_Rdata <= mem[b.mem_Address];
        if (b4.mem_Write) mem4[b4.mem_Address] <= b4.mem_Wdata;
        if (b4.mem_Read)  b4.mem_Rdata <= mem4[b4.mem_Address];
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check_eq("strobe_excl", 64'(b.mem_Read & b.mem_Write), 64'd0);
            check_eq("done_excl", 64'(b.done0 & b.done1), 64'd0);
            check_eq("strobe_busy", 64'((b.mem_Read | b.mem_Write) & ~b.busy), 64'd0);
            if (b.done0 || b.done1) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 64'(b.done1), 64'd2);
                end else begin
                    e = sb.pop_front();
                    if (e.rd) exp_rdata = e.data;
                    check_eq("done_port", 64'(b.done1), 64'(e.port));
                    check_eq("grant", 64'(b.grant), 64'(e.port));
                    check_eq("rdata", 64'(b.rdata), 64'(exp_rdata));
                end
            end
        end
    end

    task automatic set_port(input int port, input logic req, input logic we,
                            input logic [8:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            b.req0 = req; b.we0 = we; b.addr0 = addr; b.wdata0 = wd;
        end else begin
            b.req1 = req; b.we1 = we; b.addr1 = addr; b.wdata1 = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int port, input logic we, input logic [8:0] addr,
                           input logic [31:0] wd, input bit use_alt, input logic [8:0] alt,
                           output int strobes, output int lat);
        bit got = 0;
        sb.push_back('{port, !we, we ? 32'd0 : exp_mem[addr]});
        if (we) exp_mem[addr] = wd;
        set_port(port, 1'b1, we, addr, wd);
        strobes = 0;
        lat = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (b.mem_Read || b.mem_Write) begin
                strobes++;
                check_eq("mem_addr", 64'(b.mem_Address), 64'(addr));
                check_eq("mem_we", 64'(b.mem_Write), 64'(we));
                if (we) check_eq("mem_wdata", 64'(b.mem_Wdata), 64'(wd));
                if (use_alt) set_port(port, 1'b1, we, alt, wd);
            end
            if ((port == 0 && b.done0) || (port == 1 && b.done1)) begin
                got = 1;
                set_port(port, 1'b0, 1'b0, 9'h000, 32'd0);
            end
        end
        if (!got) check_eq("txn_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int strobes, lat, n, idx, st, ndone;
        int seq [6];
        int d [2];
        bit seen;

        set_port(0, 1'b0, 1'b0, 9'h000, 32'd0);
        set_port(1, 1'b0, 1'b0, 9'h000, 32'd0);
        b4.req0 = 0; b4.we0 = 0; b4.addr0 = '0; b4.wdata0 = '0;
        b4.req1 = 0; b4.we1 = 0; b4.addr1 = '0; b4.wdata1 = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = init_val(i);
            mem4[i] = init_val(i);
            exp_mem[i] = init_val(i);
        end

        // Reset values, then idle stability
        do_reset();
        check_eq("rst_done0", 64'(b.done0), 64'd0);
        check_eq("rst_done1", 64'(b.done1), 64'd0);
        check_eq("rst_read", 64'(b.mem_Read), 64'd0);
        check_eq("rst_write", 64'(b.mem_Write), 64'd0);
        check_eq("rst_addr", 64'(b.mem_Address), 64'd0);
        check_eq("rst_wdata", 64'(b.mem_Wdata), 64'd0);
        check_eq("rst_rdata", 64'(b.rdata), 64'd0);
        check_eq("rst_busy", 64'(b.busy), 64'd0);
        check_eq("rst_grant", 64'(b.grant), 64'd1);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_busy", 64'(b.busy), 64'd0);
            check_eq("idle_strobe", 64'(b.mem_Read | b.mem_Write), 64'd0);
            check_eq("idle_grant", 64'(b.grant), 64'd1);
            check_eq("idle_addr", 64'(b.mem_Address), 64'd0);
        end
        @(posedge clk); #1;

        // Clear during ACCESS of a port 0 read aborts it
        set_port(0, 1'b1, 1'b0, 9'h010, 32'd0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (b.mem_Read) seen = 1;
        end
        check_eq("abort_strobe_seen", 64'(seen), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 9'h000, 32'd0);
        check_eq("abort_busy", 64'(b.busy), 64'd0);
        check_eq("abort_strobes", 64'(b.mem_Read | b.mem_Write), 64'd0);
        check_eq("abort_done0", 64'(b.done0), 64'd0);
        check_eq("abort_rdata", 64'(b.rdata), 64'(exp_rdata));
        repeat (8) begin
            @(negedge clk);
            check_eq("abort_no_done", 64'(b.done0), 64'd0);
        end
        @(posedge clk); #1;

        // Port 0 write, then port 1 reads it back
        run_txn(0, 1'b1, 9'h054, 32'h0000_0097, 0, 9'h000, strobes, lat);
        check_eq("wr_strobe_cycles", 64'(strobes), 64'd2);
        check_eq("wr_latency", 64'(lat), 64'd4);
        check_eq("wr_rdata_unchanged", 64'(b.rdata), 64'd0);
        run_txn(1, 1'b0, 9'h054, 32'd0, 0, 9'h000, strobes, lat);
        check_eq("rd_back", 64'(b.rdata), 64'h0000_0097);
        check_eq("rd_strobe_cycles", 64'(strobes), 64'd2);

        // Address change during ACCESS is ignored
        run_txn(1, 1'b0, 9'h092, 32'd0, 1, 9'h0B9, strobes, lat);
        check_eq("addr_hold_rdata", 64'(b.rdata), 64'(init_val(9'h092)));

        // Both ports continuously requesting from reset
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{i % 2, 1'b1, exp_mem[(i % 2 == 0) ? 9'h020 : 9'h021]});
        end
        set_port(0, 1'b1, 1'b0, 9'h020, 32'd0);
        set_port(1, 1'b1, 1'b0, 9'h021, 32'd0);
        n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            @(negedge clk);
            if (b.done0 || b.done1) begin
                seq[n] = int'(b.done1);
                n++;
                if (n == 6) begin
                    set_port(0, 1'b0, 1'b0, 9'h000, 32'd0);
                    set_port(1, 1'b0, 1'b0, 9'h000, 32'd0);
                end
            end
        end
        check_eq("rr_count", 64'(n), 64'd6);
        for (int i = 0; i < 6; i++) check_eq($sformatf("rr_seq%0d", i), 64'(seq[i]), 64'(i % 2));
        repeat (4) @(posedge clk); #1;

        // WAIT_CYCLES = 4: latency, strobe length and back-to-back spacing
        b4.req0 = 1'b1; b4.we0 = 1'b0; b4.addr0 = 9'h033;
        idx = 0; st = 0; ndone = 0; d[0] = 0; d[1] = 0;
        for (int c = 0; c < 60 && ndone < 2; c++) begin
            @(negedge clk);
            idx++;
            if ((b4.mem_Read || b4.mem_Write) && ndone == 0) st++;
            if (b4.done1) check_eq("w4_done1", 64'(b4.done1), 64'd0);
            if (b4.done0) begin
                d[ndone] = idx;
                check_eq("w4_rdata", 64'(b4.rdata), 64'(init_val(9'h033)));
                ndone++;
                if (ndone == 2) b4.req0 = 1'b0;
            end
        end
        check_eq("w4_ndone", 64'(ndone), 64'd2);
        check_eq("w4_strobe_cycles", 64'(st), 64'd4);
        check_eq("w4_latency", 64'(d[0]), 64'd6);
        check_eq("w4_spacing", 64'(d[1] - d[0]), 64'd6);
        repeat (3) @(posedge clk); #1;
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
